// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, range-checks the immediate,
// and tags each word with a sequential byte address. Optional macro: INSTR_ENCODER_NOP_ON_ERR_EN.
module instr_encoder #(
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_sticky,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I_ALU  = 7'b0010011;
    localparam logic [6:0]  OP_I_LOAD = 7'b0000011;
    localparam logic [6:0]  OP_I_JALR = 7'b1100111;
    localparam logic [6:0]  OP_S      = 7'b0100011;
    localparam logic [6:0]  OP_B      = 7'b1100011;
    localparam logic [6:0]  OP_U_LUI  = 7'b0110111;
    localparam logic [6:0]  OP_U_AUI  = 7'b0010111;
    localparam logic [6:0]  OP_J      = 7'b1101111;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

`ifdef INSTR_ENCODER_NOP_ON_ERR_EN
    localparam logic NOP_ON_ERR = 1'b1;
`else
    localparam logic NOP_ON_ERR = 1'b0;
`endif

    // True when every bit from msb upward equals bit msb, i.e. v fits in msb+1 signed bits.
    function automatic logic sext_fits(input logic [31:0] v, input logic [31:0] upper_mask);
        return ((v & upper_mask) == 32'h0000_0000) || ((v & upper_mask) == upper_mask);
    endfunction

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic [ADDR_W-1:0] cnt_q,       cnt_d;
    logic              err_sticky_q, err_sticky_d;
    logic [7:0]        err_count_q,  err_count_d;
    logic [ADDR_W-1:0] err_addr_q,   err_addr_d;

    logic        legal_s;
    logic [31:0] enc_s;
    logic        accept_s;
    logic        emit_s;
    logic        reject_s;
    logic [31:0] word_s;

    assign in_ready = !out_valid_q || out_ready;
    assign accept_s = in_valid && in_ready;
    assign reject_s = accept_s && !legal_s;
    assign emit_s   = accept_s && (legal_s || NOP_ON_ERR);
    assign word_s   = legal_s ? enc_s : NOP_WORD;

    // Field packing and immediate legality per instruction format.
    always_comb begin
        enc_s   = 32'h0000_0000;
        legal_s = 1'b0;
        case (opcode)
            OP_R: begin
                enc_s   = {funct7, rs2, rs1, funct3, rd, opcode};
                legal_s = 1'b1;
            end
            OP_I_ALU, OP_I_LOAD, OP_I_JALR: begin
                enc_s   = {imm[11:0], rs1, funct3, rd, opcode};
                legal_s = sext_fits(imm, 32'hFFFF_F800);
            end
            OP_S: begin
                enc_s   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal_s = sext_fits(imm, 32'hFFFF_F800);
            end
            OP_B: begin
                enc_s   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal_s = sext_fits(imm, 32'hFFFF_F000) && (imm[0] == 1'b0);
            end
            OP_U_LUI, OP_U_AUI: begin
                enc_s   = {imm[31:12], rd, opcode};
                legal_s = (imm[11:0] == 12'h000);
            end
            OP_J: begin
                enc_s   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal_s = sext_fits(imm, 32'hFFF0_0000) && (imm[0] == 1'b0);
            end
            default: begin
                enc_s   = 32'h0000_0000;
                legal_s = 1'b0;
            end
        endcase
    end

    // Next-state for output stage, address counter and error bookkeeping.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_addr_d   = out_addr_q;
        cnt_d        = cnt_q;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        err_addr_d   = err_addr_q;

        if (emit_s) begin
            out_valid_d = 1'b1;
            out_instr_d = word_s;
            out_addr_d  = cnt_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // The word accepted alongside clr keeps the pre-clr address captured above.
        if (clr) begin
            cnt_d = BASE_ADDR;
        end else if (emit_s) begin
            cnt_d = cnt_q + ADDR_W'(3'd4);
        end else begin
            cnt_d = cnt_q;
        end

        if (clr) begin
            err_sticky_d = 1'b0;
            err_count_d  = 8'h00;
        end else if (reject_s) begin
            err_sticky_d = 1'b1;
            err_count_d  = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'h01;
        end else begin
            err_sticky_d = err_sticky_q;
            err_count_d  = err_count_q;
        end

        if (reject_s) begin
            err_addr_d = cnt_q;
        end else begin
            err_addr_d = err_addr_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'h0000_0000;
            out_addr_q   <= {ADDR_W{1'b0}};
            cnt_q        <= BASE_ADDR;
            err_sticky_q <= 1'b0;
            err_count_q  <= 8'h00;
            err_addr_q   <= {ADDR_W{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_addr_q   <= out_addr_d;
            cnt_q        <= cnt_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_addr   = out_addr_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against an arithmetic reference model;
// a second instance with ADDR_W=4 shares the stimulus to cover address wrap.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst, clr, in_valid, out_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;

    logic        in_ready, out_valid, err_sticky;
    logic [31:0] out_instr, out_addr, err_addr;
    logic [7:0]  err_count;

    logic        w4_in_ready, w4_out_valid, w4_err_sticky;
    logic [31:0] w4_out_instr;
    logic [3:0]  w4_out_addr, w4_err_addr;
    logic [7:0]  w4_err_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic        m_valid, m_sticky;
    logic [31:0] m_instr, m_addr, m_cnt, m_eaddr;
    int          m_count;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_sticky(err_sticky), .err_count(err_count), .err_addr(err_addr)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) dut_w4 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(w4_in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .out_valid(w4_out_valid), .out_ready(out_ready), .out_instr(w4_out_instr),
        .out_addr(w4_out_addr), .err_sticky(w4_err_sticky), .err_count(w4_err_count),
        .err_addr(w4_err_addr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] bitn(input logic [31:0] v, input int n);
        return (v >> n) & 32'h1;
    endfunction

    // Encoding computed from the field-placement table with shifts and masks.
    function automatic logic [31:0] ref_encode(input logic [6:0] op, input logic [4:0] f_rd,
                                               input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [31:0] v, output logic legal);
        int          s;
        logic [31:0] base;
        s    = $signed(v);
        base = (32'(f_rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (op)
            7'b0110011: begin
                legal = 1'b1;
                return (32'(f7) << 25) | (32'(f_rs2) << 20) | base | (32'(f_rd) << 7);
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                legal = (s >= -2048) && (s <= 2047);
                return ((v & 32'hFFF) << 20) | base | (32'(f_rd) << 7);
            end
            7'b0100011: begin
                legal = (s >= -2048) && (s <= 2047);
                return (((v >> 5) & 32'h7F) << 25) | (32'(f_rs2) << 20) | base | ((v & 32'h1F) << 7);
            end
            7'b1100011: begin
                legal = (s >= -4096) && (s <= 4094) && ((s % 2) == 0);
                return (bitn(v, 12) << 31) | (((v >> 5) & 32'h3F) << 25) | (32'(f_rs2) << 20) |
                       base | (((v >> 1) & 32'hF) << 8) | (bitn(v, 11) << 7);
            end
            7'b0110111, 7'b0010111: begin
                legal = ((v % 32'd4096) == 32'd0);
                return (v & 32'hFFFF_F000) | (32'(f_rd) << 7) | 32'(op);
            end
            7'b1101111: begin
                legal = (s >= -1048576) && (s <= 1048574) && ((s % 2) == 0);
                return (bitn(v, 20) << 31) | (((v >> 1) & 32'h3FF) << 21) | (bitn(v, 11) << 20) |
                       (((v >> 12) & 32'hFF) << 12) | (32'(f_rd) << 7) | 32'(op);
            end
            default: begin
                legal = 1'b0;
                return 32'h0;
            end
        endcase
    endfunction

    // One clock: check in_ready, advance the model, compare every output of both instances.
    task automatic step();
        logic        exp_ready, acc, legal, emit;
        logic [31:0] w;
        #1;
        exp_ready = !m_valid || out_ready;
        check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
        check_eq("w4_in_ready", 32'(w4_in_ready), 32'(exp_ready));
        acc = in_valid && exp_ready;
        w   = ref_encode(opcode, rd, rs1, rs2, funct3, funct7, imm, legal);
`ifdef INSTR_ENCODER_NOP_ON_ERR_EN
        emit = acc;
        if (!legal) w = 32'h0000_0013;
`else
        emit = acc && legal;
`endif
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0; m_instr = 32'h0; m_addr = 32'h0; m_cnt = 32'h0;
            m_sticky = 1'b0; m_count = 0; m_eaddr = 32'h0;
        end else begin
            if (acc && !legal) m_eaddr = m_cnt;
            if (clr) begin
                m_sticky = 1'b0; m_count = 0;
            end else if (acc && !legal) begin
                m_sticky = 1'b1; m_count = (m_count < 255) ? m_count + 1 : 255;
            end
            if (emit) begin
                m_valid = 1'b1; m_instr = w; m_addr = m_cnt;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (clr) m_cnt = 32'h0;
            else if (emit) m_cnt = m_cnt + 32'd4;
        end
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_instr", out_instr, m_instr);
        check_eq("out_addr", out_addr, m_addr);
        check_eq("err_sticky", 32'(err_sticky), 32'(m_sticky));
        check_eq("err_count", 32'(err_count), 32'(m_count));
        check_eq("err_addr", err_addr, m_eaddr);
        check_eq("w4_out_valid", 32'(w4_out_valid), 32'(m_valid));
        check_eq("w4_out_instr", w4_out_instr, m_instr);
        check_eq("w4_out_addr", 32'(w4_out_addr), m_addr % 32'd16);
        check_eq("w4_err_count", 32'(w4_err_count), 32'(m_count));
        check_eq("w4_err_addr", 32'(w4_err_addr), m_eaddr % 32'd16);
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] f_rd, input logic [4:0] f_rs1,
                         input logic [4:0] f_rs2, input logic [2:0] f3, input logic [31:0] v);
        in_valid = 1'b1; opcode = op; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2;
        funct3 = f3; funct7 = 7'h00; imm = v;
    endtask

    function automatic logic [6:0] pick_op(input int k);
        case (k)
            0: return 7'b0110011;
            1: return 7'b0010011;
            2: return 7'b0000011;
            3: return 7'b1100111;
            4: return 7'b0100011;
            5: return 7'b1100011;
            6: return 7'b0110111;
            7: return 7'b0010111;
            8: return 7'b1101111;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] pick_imm();
        int k;
        k = $urandom_range(0, 15);
        case (k)
            0: return 32'd2047;
            1: return 32'd2048;
            2: return -32'sd2048;
            3: return -32'sd2049;
            4: return 32'd4094;
            5: return 32'd4095;
            6: return -32'sd4096;
            7: return 32'd1048574;
            8: return 32'd1048576;
            9: return -32'sd1048576;
            10: return $urandom & 32'hFFFF_F000;
            11: return $urandom;
            default: return 32'($signed($urandom_range(0, 10000)) - 5000);
        endcase
    endfunction

    initial begin
        int          k;
        logic [31:0] saved;
        rst = 1'b1; clr = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        drive(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0); in_valid = 1'b0;
        m_valid = 1'b0; m_instr = 32'h0; m_addr = 32'h0; m_cnt = 32'h0;
        m_sticky = 1'b0; m_count = 0; m_eaddr = 32'h0;
        step(); step();
        rst = 1'b0;
        step();
        check_eq("reset_out_valid", 32'(out_valid), 32'h0);
        check_eq("reset_err_count", 32'(err_count), 32'h0);

        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5); step();
        check_eq("addi_word", out_instr, 32'h0050_0093);
        check_eq("addi_addr", out_addr, 32'h0);
        drive(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8); step();
        check_eq("sw_word", out_instr, 32'h0020_A423);
        check_eq("sw_addr", out_addr, 32'h4);
        drive(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4); step();
        check_eq("beq_word", out_instr, 32'hFE00_0EE3);
        drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048); step();
        check_eq("jal_word", out_instr, 32'h0010_00EF);
        check_eq("w4_addr_12", 32'(w4_out_addr), 32'd12);
        drive(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000); step();
        check_eq("lui_word", out_instr, 32'h1234_52B7);
        check_eq("w4_addr_wrap", 32'(w4_out_addr), 32'd0);

        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048); step();
        drive(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3); step();
        check_eq("err_count_two", 32'(err_count), 32'd2);
        check_eq("err_sticky_set", 32'(err_sticky), 32'd1);
`ifdef INSTR_ENCODER_NOP_ON_ERR_EN
        check_eq("nop_word", out_instr, 32'h0000_0013);
        check_eq("err_addr_nop", err_addr, 32'd24);
`else
        check_eq("err_no_word", 32'(out_valid), 32'd0);
        check_eq("err_addr", err_addr, 32'd20);
`endif
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5); step();
`ifdef INSTR_ENCODER_NOP_ON_ERR_EN
        check_eq("after_err_addr", out_addr, 32'd28);
`else
        check_eq("after_err_addr", out_addr, 32'd20);
`endif

        out_ready = 1'b0;
        saved = m_cnt;
        for (int i = 0; i < 5; i++) begin
            drive(7'b0110011, 5'(i), 5'd3, 5'd4, 3'd0, 32'h0); step();
            check_eq("stall_instr", out_instr, 32'h0050_0093);
        end
        check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        drive(7'b0110011, 5'd7, 5'd3, 5'd4, 3'd0, 32'h0); step();
        check_eq("drain_addr", out_addr, saved);
        drive(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 32'd1); step();
        check_eq("drain_next", out_addr, saved + 32'd4);

        saved = m_cnt;
        clr = 1'b1;
        drive(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 32'd2); step();
        clr = 1'b0;
        check_eq("clr_old_addr", out_addr, saved);
        check_eq("clr_err_count", 32'(err_count), 32'd0);
        drive(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 32'd3); step();
        check_eq("clr_base_addr", out_addr, 32'd0);

        out_ready = 1'b0;
        step();
        rst = 1'b1; step(); rst = 1'b0;
        check_eq("rst_stall_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 10);
            drive(pick_op(k), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), pick_imm());
            funct7    = 7'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate generator: packs decoded RV32I fields (opcode, rd, rs1, rs2, funct3, funct7, 32-bit immediate) into a 32-bit instruction word.
- Range-checks the immediate for the opcode's format and tags each emitted word with a sequential byte address.
- Feeds the test/boot loader that writes instruction memory, and the self-checking bench that round-trips words through the immediate generator.
- Valid/ready on both sides, one output register stage.

Parameters:
- ADDR_W, 32, width of the address counter and out_addr.
- BASE_ADDR, 32'h0000_0000, address loaded at reset and on clr; must be 4-byte aligned.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous; reloads the address counter to BASE_ADDR and clears err_sticky/err_count; pipeline contents untouched.
- in_valid  input  1  request carries valid fields.
- in_ready  output  1  block accepts the request this cycle.
- opcode  input  7  instr[6:0].
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  function field.
- funct7  input  7  function field; used only for R-type.
- imm  input  32  signed immediate; for U-type this is the final value (low 12 bits must be 0).
- out_valid  output  1  out_instr/out_addr hold a valid word.
- out_ready  input  1  consumer takes the word.
- out_instr  output  32  encoded instruction.
- out_addr  output  ADDR_W  byte address of out_instr.
- err_sticky  output  1  set by any rejected request; cleared by rst or clr.
- err_count  output  8  number of rejected requests; saturates at 255.
- err_addr  output  ADDR_W  counter value at the most recent rejection.

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0, out_instr=0, out_addr=0.
  - Address counter loaded to BASE_ADDR.
  - err_sticky=0, err_count=0, err_addr=0.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Latency: exactly 1 cycle from accept to out_valid.
- Output stability: while out_valid && !out_ready, out_instr and out_addr hold stable.
- Output register update on each edge:
  - Accept of a legal request: loads out_instr and out_addr = counter; counter += 4.
  - Otherwise, if out_ready: out_valid clears.
- Format by opcode:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Any other opcode is illegal.
- Encoding (standard RV32I field placement):
  - R = {funct7, rs2, rs1, funct3, rd, op}.
  - I = {imm[11:0], rs1, funct3, rd, op}.
  - S = {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - U = {imm[31:12], rd, op}.
  - J = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Legality (immediate viewed as signed 32-bit):
  - I, S: -2048..2047.
  - B: -4096..4094 and imm[0]=0.
  - J: -1048576..1048574 and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored.
- Rejected request (illegal opcode or out-of-range immediate):
  - Still accepted (handshake completes).
  - No output word is produced and the counter does not advance.
  - err_sticky set; err_count incremented (saturating); err_addr = current counter.
- Counter wraps modulo 2^ADDR_W with no flag.
- Simultaneous events:
  - clr with a legal accept: the accepted word gets the pre-clr counter value; counter becomes BASE_ADDR.
  - clr with a rejection: clr wins, so err_count=0 and err_sticky=0.
  - rst overrides everything, including mid-stall: the held output word is discarded.

Optional Feature:
- Macro: INSTR_ENCODER_NOP_ON_ERR_EN.
- Defined: a rejected request emits NOP 32'h0000_0013 at the current address. The counter advances by 4 and the error outputs update as normal.
- Undefined: rejected requests are dropped as described above.

Test Plan:
- ADDI opcode 0010011, rd=1, rs1=0, f3=0, imm=5 after reset → out_instr=32'h0050_0093, out_addr=0 one cycle later; next word at out_addr=4.
- SW (0100011), rs1=1, rs2=2, f3=010, imm=8 → 32'h0020_A423.
- Three branch/jump/upper encodings:
  - BEQ (1100011), rs1=rs2=0, imm=-4 → 32'hFE00_0EE3.
  - JAL (1101111), rd=1, imm=2048 → 32'h0010_00EF.
  - LUI (0110111), rd=5, imm=32'h1234_5000 → 32'h1234_52B7.
- ADDI with imm=2048, then BEQ with imm=3 → no out_valid; err_count=2, err_sticky=1, err_addr unchanged counter, next legal word keeps that address. With INSTR_ENCODER_NOP_ON_ERR_EN: two 32'h0000_0013 words at consecutive addresses.
- out_ready held 0 for 5 cycles with in_valid=1 → in_ready=0, out_instr stable, counter unchanged; on release, words drain in order with contiguous addresses.
- Edge cases:
  - ADDR_W=4, 5 legal words → addresses 0, 4, 8, 12, 0.
  - clr asserted with an accept → that word keeps the old address, next word gets BASE_ADDR.
  - rst asserted while stalled → out_valid=0 the next cycle.
